// File: rtl/mem_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_arbiter_pkg
// Description : Shared types and constants for the IF/D memory access
//               arbiter: FSM state encoding, transaction owner codes and
//               byte-enable patterns.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // Byte enables are ordered {hi, lo}; the high lane holds odd byte addresses.
  localparam logic [1:0] c_BE_NONE = 2'b00;
  localparam logic [1:0] c_BE_LO   = 2'b01;
  localparam logic [1:0] c_BE_HI   = 2'b10;
  localparam logic [1:0] c_BE_HALF = 2'b11;

endpackage : mem_access_arbiter_pkg
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational byte-lane handling for a 16-bit memory word.
//               Generates byte enables, replicates byte store data onto both
//               lanes and extracts/extends byte load data.
// Ports       : i_bh     - 1 = halfword access, 0 = byte access
//               i_addr0  - byte address bit 0 (lane select for byte access)
//               i_unsig  - byte load: 1 = zero-extend, 0 = sign-extend
//               i_wdata  - raw store data (byte store uses [7:0])
//               i_rdata  - raw memory read word
//               o_be     - byte enables {hi, lo}
//               o_wdata  - lane-replicated store data
//               o_rdata  - extended load data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import mem_access_arbiter_pkg::*;
(
  input  logic        i_bh,
  input  logic        i_addr0,
  input  logic        i_unsig,
  input  logic [15:0] i_wdata,
  input  logic [15:0] i_rdata,
  output logic [1:0]  o_be,
  output logic [15:0] o_wdata,
  output logic [15:0] o_rdata
);

  logic [7:0] w_byte;

  always_comb begin
    o_be    = c_BE_NONE;
    o_wdata = 16'h0000;
    o_rdata = 16'h0000;
    w_byte  = 8'h00;
    if (i_bh) begin
      o_be    = c_BE_HALF;
      o_wdata = i_wdata;
      o_rdata = i_rdata;
    end else begin
      o_be    = i_addr0 ? c_BE_HI : c_BE_LO;
      // Both lanes carry the byte so the enable alone picks the target lane.
      o_wdata = {2{i_wdata[7:0]}};
      w_byte  = i_addr0 ? i_rdata[15:8] : i_rdata[7:0];
      o_rdata = i_unsig ? {8'h00, w_byte} : {{8{w_byte[7]}}, w_byte};
    end
  end

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_arbiter
// Description : Shares one single-port 16-bit memory between instruction
//               fetch (IF) and data load/store (D). One access in flight at a
//               time: IDLE -> ACCESS (held until mem_ready) -> RESP (one-cycle
//               valid). D has priority except when IF has been starved for
//               STARVE_MAX consecutive D grants.
// Ports       : clk, rst_n                     - clock, async active-low reset
//               if_req/if_addr/if_gnt          - fetch request handshake
//               if_valid/if_rdata              - fetch response
//               d_req/d_we/d_bh/d_unsig/d_addr/d_wdata/d_gnt - data request
//               d_valid/d_rdata/d_err          - data response
//               mem_en/mem_we/mem_be/mem_addr/mem_wdata      - memory command
//               mem_rdata/mem_ready            - memory response
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [15:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_bh,
  input  logic              d_unsig,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [15:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [15:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_be,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam logic [3:0]        c_STARVE_MAX = 4'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] c_HALF_MASK  = ~{{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next_state;
  owner_t              r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic                r_bh;
  logic                r_unsig;
  logic                r_err;
  logic [15:0]         r_wdata;
  logic [3:0]          r_starve;
  logic [15:0]         r_if_rdata;
  logic [15:0]         r_d_rdata;

  logic                w_arb_open;
  logic                w_if_win;
  logic                w_d_misalign;
  logic [1:0]          w_be;
  logic [15:0]         w_wdata;
  logic [15:0]         w_ld_data;

  // RESP is treated as idle so a waiting requester costs only one bubble.
  // Gating with rst_n keeps grants low while reset is held.
  assign w_arb_open   = rst_n && ((r_state == ST_IDLE) || (r_state == ST_RESP));
  assign w_if_win     = if_req && (!d_req || (r_starve == c_STARVE_MAX));
  assign w_d_misalign = d_bh && d_addr[0];

  mem_lane_align u_lane_align (
    .i_bh    (r_bh),
    .i_addr0 (r_addr[0]),
    .i_unsig (r_unsig),
    .i_wdata (r_wdata),
    .i_rdata (mem_rdata),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_rdata (w_ld_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and outputs
  always_comb begin
    w_next_state = r_state;
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    if_valid     = 1'b0;
    d_valid      = 1'b0;
    d_err        = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_be       = c_BE_NONE;
    mem_addr     = '0;
    mem_wdata    = 16'h0000;

    if (w_arb_open) begin
      if_gnt = w_if_win;
      d_gnt  = d_req && !w_if_win;
    end

    case (r_state)
      ST_IDLE, ST_RESP: begin
        if (r_state == ST_RESP) begin
          if_valid = (r_owner == OWN_IF);
          d_valid  = (r_owner == OWN_D);
          d_err    = (r_owner == OWN_D) && r_err;
        end
        if (if_gnt) begin
          w_next_state = ST_ACCESS;
        end else if (d_gnt) begin
          // A misaligned halfword never touches memory.
          w_next_state = w_d_misalign ? ST_RESP : ST_ACCESS;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = r_we;
        mem_be    = w_be;
        mem_addr  = r_addr[ADDR_W-1:1];
        mem_wdata = w_wdata;
        if (mem_ready) begin
          w_next_state = ST_RESP;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Command register, captured at grant and held through ACCESS/RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_IF;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_bh    <= 1'b0;
      r_unsig <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= 16'h0000;
    end else if (if_gnt) begin
      r_owner <= OWN_IF;
      r_addr  <= if_addr & c_HALF_MASK;
      r_we    <= 1'b0;
      r_bh    <= 1'b1;
      r_unsig <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= 16'h0000;
    end else if (d_gnt) begin
      r_owner <= OWN_D;
      r_addr  <= d_addr;
      r_we    <= d_we && !w_d_misalign;
      r_bh    <= d_bh;
      r_unsig <= d_unsig;
      r_err   <= w_d_misalign;
      r_wdata <= d_wdata;
    end
  end

  // Response data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_rdata <= 16'h0000;
      r_d_rdata  <= 16'h0000;
    end else if ((r_state == ST_ACCESS) && mem_ready) begin
      if (r_owner == OWN_IF) begin
        r_if_rdata <= mem_rdata;
      end else begin
        r_d_rdata  <= w_ld_data;
      end
    end else if (d_gnt && w_d_misalign) begin
      r_d_rdata <= 16'h0000;
    end
  end

  assign if_rdata = r_if_rdata;
  assign d_rdata  = r_d_rdata;

  // Starvation counter: D grants taken while IF is kept waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= 4'd0;
    end else if (!if_req || if_gnt) begin
      r_starve <= 4'd0;
    end else if (d_gnt && (r_starve != c_STARVE_MAX)) begin
      r_starve <= r_starve + 4'd1;
    end
  end

endmodule : mem_access_arbiter
`default_nettype wire
